// File: rtl/regfile_2w2r_pkg.sv
// Shared defaults and reset constant for the dual-write register file.
package regfile_2w2r_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  // Every stored bit (data and pending) resets to this value.
  localparam logic RESET_BIT = 1'b0;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port output selection: reset/zero-register forcing, same-cycle write
// bypass (port 1 over port 0) and pending-bit bypass.
module regfile_bypass_mux
  import regfile_2w2r_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              stored_pend,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_pend
);

  logic is_zero;
  logic hit0;
  logic hit1;
  logic alloc_hit;

  assign is_zero   = ZERO_REG && (rd_addr == '0);
  assign hit0      = wr_en0 && (wr_addr0 == rd_addr);
  assign hit1      = wr_en1 && (wr_addr1 == rd_addr);
  assign alloc_hit = alloc_en && (alloc_addr == rd_addr);

  // Pick the visible word and pending flag for this port.
  always_comb begin
    // NOTE: default every output first so no path leaves it unassigned (no latch).
    rd_data = stored_data;
    rd_pend = stored_pend;
    if (rst || is_zero) begin
      rd_data = {DATA_W{RESET_BIT}};
      rd_pend = RESET_BIT;
    end else if (BYPASS) begin
      if (hit1)      rd_data = wr_data1;
      else if (hit0) rd_data = wr_data0;
      // A retiring write clears the flag early unless a new producer claims it.
      if ((hit0 || hit1) && !alloc_hit) rd_pend = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_2w2r.sv
// Register file with two synchronous write ports, two combinational read ports
// and a per-register pending scoreboard.
module regfile_2w2r
  import regfile_2w2r_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_pend_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_pend_b,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;

  // Commit writes, port 1 taking priority on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the whole array is reset because reads must return 0 after reset;
      // this rules out a RAM macro and builds the storage from flops.
      for (int i = 0; i < DEPTH; i++) mem[i] <= {DATA_W{RESET_BIT}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!(ZERO_REG && i == 0)) begin
          // NOTE: non-blocking so every register samples pre-edge inputs.
          if (wr_en1 && wr_addr1 == ADDR_W'(i))      mem[i] <= wr_data1;
          else if (wr_en0 && wr_addr0 == ADDR_W'(i)) mem[i] <= wr_data0;
        end
      end
    end
  end

  // Scoreboard: alloc sets, any write clears, alloc wins when both hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= {DEPTH{RESET_BIT}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!(ZERO_REG && i == 0)) begin
          if (alloc_en && alloc_addr == ADDR_W'(i))
            pending[i] <= 1'b1;
          else if ((wr_en0 && wr_addr0 == ADDR_W'(i)) ||
                   (wr_en1 && wr_addr1 == ADDR_W'(i)))
            pending[i] <= 1'b0;
        end
      end
    end
  end

  regfile_bypass_mux #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_mux_a (
    .rst        (rst),
    .rd_addr    (rd_addr_a),
    .stored_data(mem[rd_addr_a]),
    .stored_pend(pending[rd_addr_a]),
    .wr_en0     (wr_en0),
    .wr_addr0   (wr_addr0),
    .wr_data0   (wr_data0),
    .wr_en1     (wr_en1),
    .wr_addr1   (wr_addr1),
    .wr_data1   (wr_data1),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .rd_data    (rd_data_a),
    .rd_pend    (rd_pend_a)
  );

  regfile_bypass_mux #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_mux_b (
    .rst        (rst),
    .rd_addr    (rd_addr_b),
    .stored_data(mem[rd_addr_b]),
    .stored_pend(pending[rd_addr_b]),
    .wr_en0     (wr_en0),
    .wr_addr0   (wr_addr0),
    .wr_data0   (wr_data0),
    .wr_en1     (wr_en1),
    .wr_addr1   (wr_addr1),
    .wr_data1   (wr_data1),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .rd_data    (rd_data_b),
    .rd_pend    (rd_pend_b)
  );

endmodule

// File: tb/tb_regfile_2w2r.sv
// Directed bench: a default instance (ZERO_REG=1, BYPASS=1) and a second
// instance (ZERO_REG=0, BYPASS=0) share stimulus so both options are covered.
module tb_regfile_2w2r;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic        wr_en0, wr_en1, alloc_en;
  logic [4:0]  wr_addr0, wr_addr1, alloc_addr;
  logic [31:0] wr_data0, wr_data1;

  logic [31:0] da, db, na, nb;
  logic        pa, pb, npa, npb;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  regfile_2w2r dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_data_a(da), .rd_pend_a(pa),
    .rd_addr_b(rd_addr_b), .rd_data_b(db), .rd_pend_b(pb),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  regfile_2w2r #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_data_a(na), .rd_pend_a(npa),
    .rd_addr_b(rd_addr_b), .rd_data_b(nb), .rd_pend_b(npb),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en0   = 1'b0;
    wr_en1   = 1'b0;
    alloc_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wr_addr0 = '0; wr_addr1 = '0; alloc_addr = '0;
    wr_data0 = '0; wr_data1 = '0;
    rd_addr_a = 5'd3; rd_addr_b = 5'd5;
    cycle(); cycle();
    check("rst_data_a", da, 32'h0);
    check("rst_data_b", db, 32'h0);
    check("rst_pend_a", {31'b0, pa}, 32'h0);
    check("rst_pend_b", {31'b0, pb}, 32'h0);
    rst = 1'b0;
    cycle();

    // Two writes on consecutive cycles, one on each port.
    wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 32'd5;
    cycle();
    wr_en0 = 1'b0;
    wr_en1 = 1'b1; wr_addr1 = 5'd3; wr_data1 = 32'd3;
    cycle();
    idle();
    #1;
    check("wr_a3", da, 32'd3);
    check("wr_b5", db, 32'd5);
    check("nb_wr_a3", na, 32'd3);
    check("nb_wr_b5", nb, 32'd5);

    // Overwrite.
    wr_en1 = 1'b1; wr_addr1 = 5'd3; wr_data1 = 32'd123321;
    cycle();
    idle();
    #1;
    check("rewrite_a3", da, 32'd123321);
    check("nb_rewrite_a3", na, 32'd123321);

    // Same address on both write ports: port 1 wins.
    rd_addr_a = 5'd7;
    wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 32'hAAAA;
    wr_en1 = 1'b1; wr_addr1 = 5'd7; wr_data1 = 32'h5555;
    #1;
    check("collide_bypass", da, 32'h5555);
    check("nb_collide_old", na, 32'h0);
    cycle();
    idle();
    #1;
    check("collide_stored", da, 32'h5555);
    check("nb_collide_stored", na, 32'h5555);

    // Bypass of a single write.
    rd_addr_a = 5'd9;
    wr_en1 = 1'b1; wr_addr1 = 5'd9; wr_data1 = 32'hDEAD;
    #1;
    check("bypass_a9", da, 32'hDEAD);
    check("nb_bypass_old", na, 32'h0);
    cycle();
    idle();
    #1;
    check("bypass_stored", da, 32'hDEAD);
    check("nb_bypass_stored", na, 32'hDEAD);

    // Scoreboard on register 4, watched by both read ports.
    rd_addr_a = 5'd4; rd_addr_b = 5'd4;
    alloc_en = 1'b1; alloc_addr = 5'd4;
    #1;
    check("alloc_not_yet", {31'b0, pa}, 32'h0);
    cycle();
    idle();
    #1;
    check("alloc_pend_a", {31'b0, pa}, 32'h1);
    check("alloc_pend_b", {31'b0, pb}, 32'h1);
    check("nb_alloc_pend", {31'b0, npa}, 32'h1);
    wr_en0 = 1'b1; wr_addr0 = 5'd4; wr_data0 = 32'h44;
    #1;
    check("clear_bypass", {31'b0, pa}, 32'h0);
    check("nb_clear_late", {31'b0, npa}, 32'h1);
    cycle();
    idle();
    #1;
    check("cleared_pend", {31'b0, pb}, 32'h0);
    check("nb_cleared_pend", {31'b0, npb}, 32'h0);
    check("cleared_data", db, 32'h44);
    alloc_en = 1'b1; alloc_addr = 5'd4;
    wr_en1 = 1'b1; wr_addr1 = 5'd4; wr_data1 = 32'h45;
    #1;
    check("alloc_wr_pend_now", {31'b0, pa}, 32'h0);
    check("alloc_wr_data_now", da, 32'h45);
    cycle();
    idle();
    #1;
    check("alloc_wr_pend", {31'b0, pa}, 32'h1);
    check("nb_alloc_wr_pend", {31'b0, npa}, 32'h1);
    check("alloc_wr_data", da, 32'h45);

    // Register 0: hardwired zero on the default instance only.
    rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    wr_en0 = 1'b1; wr_addr0 = 5'd0; wr_data0 = 32'hFFFF;
    alloc_en = 1'b1; alloc_addr = 5'd0;
    #1;
    check("zero_no_bypass", da, 32'h0);
    cycle();
    idle();
    #1;
    check("zero_data", da, 32'h0);
    check("zero_pend", {31'b0, pb}, 32'h0);
    check("nb_r0_data", na, 32'hFFFF);
    check("nb_r0_pend", {31'b0, npa}, 32'h1);

    // Reset in the middle of a pending write.
    rd_addr_a = 5'd5; rd_addr_b = 5'd4;
    wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 32'h77;
    #1;
    rst = 1'b1;
    #1;
    check("midrst_a", da, 32'h0);
    check("midrst_pend_b", {31'b0, pb}, 32'h0);
    check("nb_midrst_a", na, 32'h0);
    cycle();
    idle();
    rst = 1'b0;
    #1;
    check("post_rst_a5", da, 32'h0);
    check("post_rst_b4", db, 32'h0);
    check("post_rst_pend4", {31'b0, pb}, 32'h0);
    rd_addr_a = 5'd9;
    #1;
    check("post_rst_a9", da, 32'h0);
    check("nb_post_rst_a9", na, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
